tree_adder_ctrl: RTL

- Sequencer for the single-level, in-place tree adder. It drives the adder's shared command input through one reduction job.
- A job is: one load of the selected pixel source (mult, shadowA or shadowB), then log2(IMGSIDELENGTH) sum passes. Each pass crunches the grid 2x per axis toward pixel [0][0].
- Accepts start/abort from the frame-level control and reports busy/done plus a capture strobe when [0][0] holds the full-frame sum.

---
 rtl/tree_adder_ctrl_pkg.sv | 42 ++++
 rtl/tree_adder_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tree_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tree_adder_pkg
//  Description : Shared definitions for the in-place tree adder: command
//                encodings driven onto the adder's command bus, the pixel
//                source selector and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package tree_adder_pkg;

    // Command encodings understood by every tree adder element.
    localparam logic [3:0] CMD_HOLD      = 4'h0;
    localparam logic [3:0] CMD_LOAD_MULT = 4'h1;
    localparam logic [3:0] CMD_LOAD_SHA  = 4'h2;
    localparam logic [3:0] CMD_LOAD_SHB  = 4'h3;
    localparam logic [3:0] CMD_SUM       = 4'h4;

    typedef enum logic [1:0] {
        SRC_MULT = 2'd0,
        SRC_SHA  = 2'd1,
        SRC_SHB  = 2'd2
    } src_sel_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SUM  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } ctrl_state_t;

    // Load command for a given pixel source.
    function automatic logic [3:0] src_load_cmd(input src_sel_t src);
        case (src)
            SRC_SHA: src_load_cmd = CMD_LOAD_SHA;
            SRC_SHB: src_load_cmd = CMD_LOAD_SHB;
            default: src_load_cmd = CMD_LOAD_MULT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tree_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tree_adder_ctrl
//  Description : Sequencer for the single-level in-place tree adder. Runs one
//                reduction job: a LOAD of the selected source followed by
//                LEVELS SUM passes, each optionally followed by SUM_GAP idle
//                cycles, then flags completion.
//  Ports       : clk, rst_n          clock / async active-low reset
//                start, src_sel      job request and source (sampled in IDLE)
//                abort               cancel a running job
//                cmd_out             command to the adder
//                level               completed sum passes
//                busy, done          job status, done is a 1-cycle pulse
//                result_capture      pixel [0][0] holds the total (with done)
//                err                 illegal start (busy or src_sel=3)
//  Revision    : 1.0  initial release
// ============================================================================
module tree_adder_ctrl
    import tree_adder_pkg::*;
#(
    parameter int IMGSIDELENGTH = 64,
    parameter int CMD_WIDTH     = 4,
    parameter int SUM_GAP       = 1,
    parameter int LEVELS        = $clog2(IMGSIDELENGTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   src_sel,
    input  logic                         abort,
    output logic [CMD_WIDTH-1:0]         cmd_out,
    output logic [$clog2(LEVELS+1)-1:0]  level,
    output logic                         busy,
    output logic                         done,
    output logic                         result_capture,
    output logic                         err
);

    localparam int             c_lw         = $clog2(LEVELS + 1);
    localparam logic [c_lw-1:0] c_levels    = c_lw'(LEVELS);
    // Gap counter is loaded with SUM_GAP-1 and expires when it reads zero.
    localparam int             c_gap_last_i = (SUM_GAP > 0) ? SUM_GAP - 1 : 0;
    localparam logic [3:0]     c_gap_last   = 4'(c_gap_last_i);

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_nxt;
    src_sel_t            r_src;
    src_sel_t            w_src_nxt;
    logic [3:0]          r_gap;
    logic [3:0]          w_gap_nxt;
    logic [c_lw-1:0]     w_level_nxt;
    logic [CMD_WIDTH-1:0] w_cmd_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_active;
    logic                w_abort;
    logic                w_accept;

    assign w_active = (r_state != IDLE);
    assign w_abort  = abort && w_active;
    assign w_accept = !w_active && start && (src_sel != 2'd3);

    // ------------------------------------------------------------------
    // State register plus job bookkeeping (source, gap counter)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_src   <= SRC_MULT;
            r_gap   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every non-IDLE transition
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_nxt = LOAD;
                LOAD: w_state_nxt = SUM;
                SUM: begin
                    if (SUM_GAP > 0)
                        w_state_nxt = GAP;
                    else if (int'(level) + 1 < LEVELS)
                        w_state_nxt = SUM;
                    else
                        w_state_nxt = DONE;
                end
                GAP: begin
                    // level already counts the pass that preceded this gap
                    if (r_gap == 4'd0)
                        w_state_nxt = (level < c_levels) ? SUM : DONE;
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / counter next values. Outputs are registered from the next
    // state so cmd_out lines up with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        w_src_nxt = w_accept ? src_sel_t'(src_sel) : r_src;

        w_gap_nxt = r_gap;
        if (r_state == SUM)
            w_gap_nxt = c_gap_last;
        else if ((r_state == GAP) && (r_gap != 4'd0))
            w_gap_nxt = r_gap - 4'd1;

        w_level_nxt = level;
        if (w_abort || w_accept)
            w_level_nxt = '0;
        else if ((r_state == SUM) && (level != c_levels))
            w_level_nxt = level + 1'b1;

        case (w_state_nxt)
            LOAD:    w_cmd_nxt = CMD_WIDTH'(src_load_cmd(w_src_nxt));
            SUM:     w_cmd_nxt = CMD_WIDTH'(CMD_SUM);
            default: w_cmd_nxt = CMD_WIDTH'(CMD_HOLD);
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == DONE);
        // abort takes precedence over a colliding start, so no error then
        w_err_nxt  = start && !w_abort && (w_active || (src_sel == 2'd3));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_out        <= CMD_WIDTH'(CMD_HOLD);
            level          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_capture <= 1'b0;
            err            <= 1'b0;
        end else begin
            cmd_out        <= w_cmd_nxt;
            level          <= w_level_nxt;
            busy           <= w_busy_nxt;
            done           <= w_done_nxt;
            result_capture <= w_done_nxt;
            err            <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire
